receiver: RTL and testbench

//  UART receive stage; consumes the serial line driven by the team's transmitter (8N1, LSB first, idle high).

---
 rtl/receiver_pkg.sv | 27 ++
 rtl/receiver_sync_2ff.sv | 31 +++
 rtl/receiver.sv | 163 ++++++++++++++++
 tb/tb_receiver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/receiver_pkg.sv
// Shared UART receive definitions: state encoding, default frame geometry, status payload.
package receiver_pkg;

    localparam int unsigned DEF_DATA_BITS  = 8;
    localparam int unsigned DEF_OVERSAMPLE = 16;

    // Encoding shared with the transmitter so both ends decode the same state values.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Sticky status presented to the consumer.
    typedef struct packed {
        logic rdy;
        logic frame_err;
        logic overrun;
    } rx_status_t;

    // Counter width helper; never returns zero so a 1-bit counter still exists.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/receiver_sync_2ff.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module receiver_sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: plain two-stage pipeline.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchroniser flops, idle-high reset so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/receiver.sv
// UART 8N1 receive stage: oversampled start detection, mid-bit sampling, sticky status flags.
module receiver
    import receiver_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    input  logic                 enb,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rdy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned SCNT_W = cnt_width(OVERSAMPLE);
    localparam int unsigned BIDX_W = cnt_width(DATA_BITS);

    localparam logic [SCNT_W-1:0] SCNT_HALF = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [SCNT_W-1:0]    scnt_q, scnt_d;
    logic [BIDX_W-1:0]    bidx_q, bidx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    rx_status_t           stat_q, stat_d;
    logic                 busy_q, busy_d;
    logic                 bit_end_c;

    receiver_sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    // A full bit period has elapsed since the last mid-bit point.
    assign bit_end_c = enb && (scnt_q == SCNT_LAST);

    // State and bit-timing counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            scnt_q  <= '0;
            bidx_q  <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bidx_q  <= bidx_d;
        end
    end

    // Next state and counters; everything advances only on a baud tick.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        bidx_d  = bidx_q;
        if (enb) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        scnt_d  = '0;
                    end
                end
                ST_START: begin
                    if (rx_s) begin
                        // Line went back high before mid start bit: treat as noise.
                        state_d = ST_IDLE;
                        scnt_d  = '0;
                    end else if (scnt_q == SCNT_HALF) begin
                        state_d = ST_DATA;
                        scnt_d  = '0;
                        bidx_d  = '0;
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (scnt_q == SCNT_LAST) begin
                        scnt_d = '0;
                        if (bidx_q == BIDX_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            bidx_d = bidx_q + BIDX_W'(1);
                        end
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
                ST_STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge is not missed.
                    if (scnt_q == SCNT_LAST) begin
                        scnt_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    scnt_d  = '0;
                end
            endcase
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q    <= '0;
            data_out_q <= '0;
            stat_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            data_out_q <= data_out_d;
            stat_q     <= stat_d;
            busy_q     <= busy_d;
        end
    end

    // Output logic: shift in data bits, commit or flag the frame at mid stop, clear on acknowledge.
    always_comb begin
        shreg_d    = shreg_q;
        data_out_d = data_out_q;
        stat_d     = stat_q;
        busy_d     = (state_q != ST_IDLE);

        if (rdy_clr) begin
            stat_d = '0;
        end

        if (bit_end_c && (state_q == ST_DATA)) begin
            shreg_d[bidx_q] = rx_s;
        end

        // Set events are applied after the clear so they win in the same cycle.
        if (bit_end_c && (state_q == ST_STOP)) begin
            if (rx_s) begin
                data_out_d     = shreg_q;
                stat_d.rdy     = 1'b1;
                stat_d.overrun = stat_q.rdy;
            end else begin
                stat_d.frame_err = 1'b1;
            end
        end
    end

    assign data_out  = data_out_q;
    assign rdy       = stat_q.rdy;
    assign frame_err = stat_q.frame_err;
    assign overrun   = stat_q.overrun;
    assign busy      = busy_q;

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for the UART receiver: every end of busy pops one expected status snapshot.
module tb_receiver;
    import receiver_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx;
    logic       enb;
    logic       rdy_clr;
    logic [7:0] data_out;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_div = 4;
    int tick_cnt = 0;

    // Expected snapshot at end of busy: {data_out, rdy, frame_err, overrun}.
    logic [10:0] exp_q[$];

    receiver dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx),
        .enb       (enb),
        .rdy_clr   (rdy_clr),
        .data_out  (data_out),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Baud tick: one clk high every tick_div clocks.
    initial begin
        enb = 1'b0;
        forever begin
            @(negedge clk);
            tick_cnt++;
            if (tick_cnt >= tick_div) begin
                tick_cnt = 0;
                enb = 1'b1;
            end else begin
                enb = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic expect_evt(input logic [7:0] d, input logic r, input logic fe, input logic ov);
        exp_q.push_back({d, r, fe, ov});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        int bit_clk;
        bit_clk = 16 * tick_div;
        rx = 1'b0;
        idle(bit_clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(bit_clk);
        end
        rx = stop_bit;
        idle(bit_clk);
        rx = 1'b1;
    endtask

    task automatic pulse_clr();
        rdy_clr = 1'b1;
        @(negedge clk);
        rdy_clr = 1'b0;
    endtask

    // Raise rdy_clr for exactly the clock in which the stop bit is sampled.
    task automatic clr_at_stop();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            #1;
            if (enb && (dut.state_q == ST_STOP) && (dut.scnt_q == 4'd15)) begin
                rdy_clr = 1'b1;
                @(negedge clk);
                #1;
                rdy_clr = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL clr_at_stop: stop sample not reached within bound");
        end
    endtask

    // Monitor: compare the status snapshot each time busy falls.
    initial begin
        logic        prev_busy;
        logic [10:0] want;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !busy) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL frame_end: unexpected end of busy, got %h", {data_out, rdy, frame_err, overrun});
                    end else begin
                        want = exp_q.pop_front();
                        check("frame_end{data,rdy,ferr,ovr}", 32'({data_out, rdy, frame_err, overrun}), 32'(want));
                    end
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        rx      = 1'b1;
        rdy_clr = 1'b0;
        idle(5);
        check("reset_data_out", 32'(data_out), 32'h00);
        check("reset_rdy", 32'(rdy), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        idle(20);

        // 1: clean frame
        expect_evt(8'hA5, 1'b1, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b1);
        check("t1_busy_low_after_stop", 32'(busy), 32'h0);
        idle(16);
        pulse_clr();
        idle(4);
        check("t1_rdy_cleared", 32'(rdy), 32'h0);

        // 2: start glitch of 5 ticks, then a real frame
        expect_evt(8'hA5, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        idle(5 * tick_div);
        rx = 1'b1;
        idle(64);
        check("t2_glitch_rdy", 32'(rdy), 32'h0);
        check("t2_glitch_ferr", 32'(frame_err), 32'h0);
        expect_evt(8'h3C, 1'b1, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b1);
        idle(16);
        pulse_clr();
        idle(16);

        // 3: bad stop bit; low stop then re-enters START and is rejected when line returns high
        expect_evt(8'h3C, 1'b0, 1'b1, 1'b0);
        expect_evt(8'h3C, 1'b0, 1'b1, 1'b0);
        send_byte(8'h55, 1'b0);
        idle(128);
        pulse_clr();
        idle(4);
        check("t3_ferr_cleared", 32'(frame_err), 32'h0);
        check("t3_data_kept", 32'(data_out), 32'h3C);

        // 4: back-to-back frames without acknowledge
        expect_evt(8'h01, 1'b1, 1'b0, 1'b0);
        expect_evt(8'hFE, 1'b1, 1'b0, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hFE, 1'b1);
        idle(32);
        pulse_clr();
        idle(16);

        // 5: acknowledge coincides with second frame's stop sample
        expect_evt(8'h12, 1'b1, 1'b0, 1'b0);
        expect_evt(8'h34, 1'b1, 1'b0, 1'b1);
        send_byte(8'h12, 1'b1);
        fork
            send_byte(8'h34, 1'b1);
            clr_at_stop();
        join
        idle(32);

        // 6: reset during bit 4 of 0xFF
        rx = 1'b0;
        idle(16 * tick_div);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            idle(16 * tick_div);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        rx = 1'b1;
        #1;
        check("t6_reset_data_out", 32'(data_out), 32'h00);
        check("t6_reset_rdy", 32'(rdy), 32'h0);
        check("t6_reset_overrun", 32'(overrun), 32'h0);
        check("t6_reset_busy", 32'(busy), 32'h0);
        idle(10);
        check("t6_reset_frame_err", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        idle(64);
        expect_evt(8'h81, 1'b1, 1'b0, 1'b0);
        send_byte(8'h81, 1'b1);
        idle(32);

        // 7: enb held high; rdy still set so the new byte overruns
        tick_div = 1;
        idle(20);
        expect_evt(8'hC3, 1'b1, 1'b0, 1'b1);
        send_byte(8'hC3, 1'b1);
        idle(40);
        check("t7_data_out", 32'(data_out), 32'hC3);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
